stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr.sv | 136 +++++++++++++
 tb/tb_stream_mux_rr.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-to-1 packet stream mux with fixed-select or round-robin arbitration
module stream_mux_rr #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 1,
  parameter int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  s,
  output logic [W-1:0]   y,
  output logic           y_valid,
  output logic           y_last,
  input  logic           y_ready,
  output logic [SW-1:0]  grant,
  output logic           busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] grant_q, grant_d;
  logic [W-1:0]  y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic          y_last_q, y_last_d;

  logic [SW-1:0] rr_sel;
  logic [SW-1:0] rr_idx;
  logic          rr_hit;
  logic          fx_hit;
  logic          in_xfer;
  logic [W-1:0]  sel_data;
  logic          sel_last;
  int            idx;

  // First requesting channel at or above ptr, wrapping modulo N.
  always_comb begin
    rr_sel = '0;
    rr_hit = 1'b0;
    rr_idx = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx    = (int'(ptr_q) + k) % N;
      rr_idx = SW'(idx);
      if (!rr_hit && in_valid[rr_idx]) begin
        rr_hit = 1'b1;
        rr_sel = rr_idx;
      end
    end
  end

  assign fx_hit = (int'(s) < N) && in_valid[s];

  always_comb begin
    in_ready = '0;
    if (state_q == ST_LOCKED) begin
      in_ready[grant_q] = !y_valid_q || y_ready;
    end
  end

  assign in_xfer  = |(in_valid & in_ready);
  assign sel_data = in_data[grant_q*W +: W];
  assign sel_last = in_last[grant_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (MODE == 1) begin
          if (rr_hit) begin
            grant_d = rr_sel;
            state_d = ST_LOCKED;
          end
        end else if (fx_hit) begin
          grant_d = s;
          state_d = ST_LOCKED;
        end
      end
      default: begin
        if (in_xfer && sel_last) begin
          state_d = ST_IDLE;
          if (MODE == 1) begin
            ptr_d = (grant_q == SW'(N - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Output stage drains on its own; an accepted beat always overwrites it.
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    if (in_xfer) begin
      y_d       = sel_data;
      y_last_d  = sel_last;
      y_valid_d = 1'b1;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;
  assign grant   = grant_q;
  assign busy    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed bench for stream_mux_rr in round-robin and fixed-select modes
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;
  logic        y_ready;

  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [1:0]  s;
  logic [7:0]  y;
  logic        y_valid;
  logic        y_last;
  logic [1:0]  grant;
  logic        busy;

  logic [3:0]  m0_valid;
  logic [31:0] m0_data;
  logic [3:0]  m0_last;
  logic [3:0]  m0_ready;
  logic [1:0]  m0_s;
  logic [7:0]  m0_y;
  logic        m0_y_valid;
  logic        m0_y_last;
  logic [1:0]  m0_grant;
  logic        m0_busy;

  int n_checks;
  int n_pass;

  stream_mux_rr #(.N(4), .W(8), .MODE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .s(s), .y(y), .y_valid(y_valid), .y_last(y_last), .y_ready(y_ready),
    .grant(grant), .busy(busy)
  );

  stream_mux_rr #(.N(4), .W(8), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m0_valid), .in_data(m0_data), .in_last(m0_last), .in_ready(m0_ready),
    .s(m0_s), .y(m0_y), .y_valid(m0_y_valid), .y_last(m0_y_last), .y_ready(y_ready),
    .grant(m0_grant), .busy(m0_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0; in_data = '0; in_last = '0; s = '0;
    m0_valid = '0; m0_data = '0; m0_last = '0; m0_s = '0;
    y_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [3:0] beat;
  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      in_data[i*8 +: 8] = 8'(i * 16 + int'(beat[i]));
      in_last[i]        = beat[i];
    end
  endtask

  logic [7:0] exp_y [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h00, 8'h01};
  logic [1:0] exp_g [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    logic [3:0] acc;
    logic       prev_busy;
    int         nb, np, idle, ch;

    n_checks = 0;
    n_pass   = 0;
    beat     = '0;

    // Reset state while rst_n is low
    rst_n = 1'b0;
    in_valid = '0; in_data = '0; in_last = '0; s = '0; y_ready = 1'b1;
    m0_valid = '0; m0_data = '0; m0_last = '0; m0_s = '0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_y", {y_valid, y_last, y}, 0);
    check("rst_ready", in_ready, 0);

    // Round-robin, four channels sending 2-beat packets back to back
    do_reset();
    beat = '0;
    drive_src();
    in_valid  = 4'hF;
    nb        = 0;
    np        = 0;
    idle      = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 40 && nb < 10; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      if (busy && !prev_busy) begin
        if (np < 5) check($sformatf("rr_grant%0d", np), grant, exp_g[np]);
        if (np > 0) check($sformatf("rr_gap%0d", np), idle, 1);
        np++;
        idle = 0;
      end
      if (!busy) idle++;
      if (!busy) check("rr_idle_ready", in_ready, 0);
      prev_busy = busy;
      cyc();
      if (acc != 0) begin
        ch = 0;
        for (int i = 0; i < 4; i++) if (acc[i]) ch = i;
        check($sformatf("rr_y%0d", nb), {y_valid, y_last, y}, {1'b1, 1'(nb % 2), exp_y[nb]});
        beat[ch] = ~beat[ch];
        drive_src();
        nb++;
      end
    end
    check("rr_beats", nb, 10);

    // Only channel 2 requests; second packet search wraps from ptr=3
    do_reset();
    in_valid = 4'b0100;
    in_last  = 4'b0100;
    in_data  = 32'h0011_0000;
    cyc();
    check("wrap_g1", {busy, grant}, {1'b1, 2'd2});
    cyc();
    check("wrap_y1", {y_valid, y_last, y}, {2'b11, 8'h11});
    check("wrap_idle", {busy, in_ready}, 5'b0);
    in_data = 32'h00A5_0000;
    cyc();
    check("wrap_g2", {busy, grant}, {1'b1, 2'd2});
    cyc();
    check("wrap_y2", {y_valid, y_last, y}, {2'b11, 8'hA5});

    // Downstream stall holds the output beat and blocks the input
    do_reset();
    in_valid = 4'b0010;
    in_data  = 32'h0000_3C00;
    cyc();
    cyc();
    y_ready = 1'b0;
    in_data = 32'h0000_3D00;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall_ready%0d", c), in_ready, 0);
      cyc();
      check($sformatf("stall_y%0d", c), {y_valid, y}, {1'b1, 8'h3C});
    end
    y_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 4'b0010);
    cyc();
    check("stall_next_y", {y_valid, y}, {1'b1, 8'h3D});

    // Fixed select: s changes mid-packet, grant holds until last beat
    do_reset();
    m0_s     = 2'd1;
    m0_valid = 4'b0011;
    m0_data  = 32'h0000_100A;
    m0_last  = 4'b0001;
    cyc();
    check("fix_g1", {m0_busy, m0_grant}, {1'b1, 2'd1});
    m0_s = 2'd0;
    cyc();
    check("fix_b0", {m0_grant, m0_y_valid, m0_y_last, m0_y}, {2'd1, 2'b10, 8'h10});
    m0_data = 32'h0000_110A;
    m0_last = 4'b0011;
    cyc();
    check("fix_b1", {m0_busy, m0_y_valid, m0_y_last, m0_y}, {3'b011, 8'h11});
    m0_valid = 4'b0001;
    cyc();
    check("fix_g0", {m0_busy, m0_grant}, {1'b1, 2'd0});
    cyc();
    check("fix_y0", {m0_y_valid, m0_y_last, m0_y}, {2'b11, 8'h0A});

    // Asynchronous reset mid-packet on channel 3
    do_reset();
    in_valid = 4'b1000;
    in_data  = 32'h3000_0000;
    cyc();
    check("ar_g3", {busy, grant}, {1'b1, 2'd3});
    cyc();
    check("ar_y", {y_valid, y}, {1'b1, 8'h30});
    #2 rst_n = 1'b0;
    #1;
    check("ar_clear", {y_valid, busy, grant, in_ready}, 0);
    in_valid = 4'b1001;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("ar_first", {busy, grant}, {1'b1, 2'd0});

    // Granted channel drops valid mid-packet while others request
    do_reset();
    in_valid = 4'b0001;
    in_data  = 32'hEEEE_EE40;
    cyc();
    cyc();
    check("drop_y", {y_valid, y}, {1'b1, 8'h40});
    in_valid = 4'b1110;
    for (int c = 0; c < 2; c++) begin
      cyc();
      check($sformatf("drop_hold%0d", c), {busy, grant, y_valid}, {1'b1, 2'd0, 1'b0});
      check($sformatf("drop_ready%0d", c), in_ready, 4'b0001);
    end
    in_valid = 4'b1111;
    in_data  = 32'hEEEE_EE41;
    in_last  = 4'b0001;
    cyc();
    check("drop_resume", {y_valid, y_last, y}, {2'b11, 8'h41});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
